// File: rtl/cam_req_arbiter.sv
// cam_req_arbiter: round-robin arbiter sharing one CAM between NUM_REQ valid/ready requesters
module cam_req_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int KEY_W   = 16,
   parameter int VAL_W   = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req_valid_i,
   output logic [NUM_REQ-1:0]       req_ready_o,
   input  logic [NUM_REQ-1:0]       req_write_i,
   input  logic [NUM_REQ*KEY_W-1:0] req_key_i,
   input  logic [NUM_REQ*VAL_W-1:0] req_val_i,
   output logic [NUM_REQ-1:0]       resp_valid_o,
   input  logic [NUM_REQ-1:0]       resp_ready_i,
   output logic                     resp_hit_o,
   output logic [VAL_W-1:0]         resp_val_o,
   output logic                     cam_read_o,
   output logic                     cam_write_o,
   output logic [KEY_W-1:0]         cam_key_o,
   output logic [VAL_W-1:0]         cam_val_o,
   input  logic                     cam_valid_i,
   input  logic [VAL_W-1:0]         cam_val_i
);
   localparam int PW = $clog2(NUM_REQ);
   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
   state_t state, state_n;
   logic [PW-1:0] ptr, gnt, gnt_q, idx;
   logic found, op_w, w_sel, hit_q;
   logic [KEY_W-1:0] key_q, k_sel;
   logic [VAL_W-1:0] val_q, v_sel, rval_q;
   always_comb begin
      gnt = '0;
      found = 1'b0;
      idx = '0;
      k_sel = '0;
      v_sel = '0;
      w_sel = 1'b0;
      // descending scan so the requester closest to ptr is the last (winning) match
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         idx = PW'((int'(ptr) + i) % NUM_REQ);
         if (req_valid_i[idx]) begin
            gnt = idx;
            found = 1'b1;
         end
      end
      for (int r = 0; r < NUM_REQ; r++) begin
         if (gnt == PW'(r)) begin
            k_sel = req_key_i[r*KEY_W +: KEY_W];
            v_sel = req_val_i[r*VAL_W +: VAL_W];
            w_sel = req_write_i[r];
         end
      end
      state_n = (state == IDLE && found && !rst) ? ISSUE :
                (state == ISSUE) ? RESP :
                (state == RESP && resp_ready_i[gnt_q]) ? IDLE : state;
      req_ready_o = (state == IDLE && found && !rst) ? NUM_REQ'(1) << gnt : '0;
      resp_valid_o = (state == RESP) ? NUM_REQ'(1) << gnt_q : '0;
      cam_read_o = (state == ISSUE) && !op_w;
      cam_write_o = (state == ISSUE) && op_w;
      cam_key_o = (state == ISSUE) ? key_q : '0;
      cam_val_o = (state == ISSUE) ? val_q : '0;
   end
   assign resp_hit_o = hit_q;
   assign resp_val_o = rval_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         ptr <= '0;
         gnt_q <= '0;
         op_w <= 1'b0;
         key_q <= '0;
         val_q <= '0;
         hit_q <= 1'b0;
         rval_q <= '0;
      end else begin
         state <= state_n;
         if (state == IDLE && found) begin
            gnt_q <= gnt;
            op_w <= w_sel;
            key_q <= k_sel;
            val_q <= v_sel;
            ptr <= (gnt == PW'(NUM_REQ - 1)) ? '0 : gnt + 1'b1;
         end
         if (state == ISSUE) begin
            hit_q <= !op_w && cam_valid_i;
            rval_q <= (!op_w && cam_valid_i) ? cam_val_i : '0;
         end
      end
   end
endmodule

// File: tb/tb_cam_req_arbiter.sv
// tb_cam_req_arbiter: directed stimulus with a response scoreboard checked by an independent monitor
module tb_cam_req_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [1:0] req_valid_i = 2'b11, req_ready_o, req_write_i = '0;
   logic [31:0] req_key_i = '0, req_val_i = '0;
   logic [1:0] resp_valid_o, resp_ready_i = 2'b11;
   logic resp_hit_o, cam_read_o, cam_write_o, cam_valid_i = 1'b0;
   logic [15:0] resp_val_o, cam_key_o, cam_val_o, cam_val_i = '0;
   int checks = 0, errors = 0;
   typedef struct packed {logic [1:0] mask; logic hit; logic [15:0] val;} exp_t;
   exp_t q[$];

   cam_req_arbiter dut (
      .clk(clk), .rst(rst), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_write_i(req_write_i), .req_key_i(req_key_i), .req_val_i(req_val_i),
      .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_hit_o(resp_hit_o),
      .resp_val_o(resp_val_o), .cam_read_o(cam_read_o), .cam_write_o(cam_write_o),
      .cam_key_o(cam_key_o), .cam_val_o(cam_val_o), .cam_valid_i(cam_valid_i),
      .cam_val_i(cam_val_i)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (|resp_valid_o) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp actual=%b required=00", resp_valid_o);
         end else if (|(resp_valid_o & resp_ready_i)) begin
            exp_t e;
            e = q.pop_front();
            chk("resp_id", 64'(resp_valid_o), 64'(e.mask));
            chk("resp_hit", 64'(resp_hit_o), 64'(e.hit));
            chk("resp_val", 64'(resp_val_o), 64'(e.val));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("drain_timeout", 64'(q.size()), 64'd0);
      step();
   endtask

   task automatic op(input int r, input logic w, input logic [15:0] key, input logic [15:0] val,
                     input logic cv, input logic [15:0] cval, input logic eh, input logic [15:0] ev);
      req_valid_i = 2'b01 << r;
      req_write_i[r] = w;
      req_key_i[r*16 +: 16] = key;
      req_val_i[r*16 +: 16] = val;
      cam_valid_i = cv;
      cam_val_i = cval;
      @(negedge clk);
      chk("op_ready", 64'(req_ready_o), 64'(2'b01 << r));
      q.push_back({2'b01 << r, eh, ev});
      step();
      req_valid_i = '0;
      req_key_i = ~req_key_i;
      req_val_i = ~req_val_i;
      req_write_i = ~req_write_i;
      @(negedge clk);
      chk("op_strobe", {62'd0, cam_write_o, cam_read_o}, {62'd0, w, !w});
      chk("op_cam_key_val", {cam_key_o, cam_val_o, req_ready_o}, {key, val, 2'b00});
      step();
      @(negedge clk);
      chk("op_resp_valid", 64'(resp_valid_o), 64'(2'b01 << r));
      step();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset with both requesters valid
      for (int c = 0; c < 2; c++) begin
         step();
         @(negedge clk);
         chk("reset_outputs", {req_ready_o, resp_valid_o, resp_hit_o, resp_val_o, cam_read_o,
                               cam_write_o, cam_key_o, cam_val_o}, 64'd0);
      end
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("first_grant", 64'(req_ready_o), 64'(2'b01));
      q.push_back({2'b01, 1'b0, 16'h0000});
      step();
      req_valid_i = '0;
      drain();
      // write, read hit, read miss
      op(0, 1'b1, 16'h0012, 16'hBEEF, 1'b1, 16'h7777, 1'b0, 16'h0000);
      op(1, 1'b0, 16'h0012, 16'h0000, 1'b1, 16'hBEEF, 1'b1, 16'hBEEF);
      op(1, 1'b0, 16'h0099, 16'h0000, 1'b0, 16'h5555, 1'b0, 16'h0000);
      // fairness
      req_key_i = '0;
      req_val_i = '0;
      req_write_i = '0;
      cam_valid_i = 1'b0;
      req_valid_i = 2'b11;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         chk("fair_ready", 64'(req_ready_o), (c % 3 == 0) ? 64'(2'b01 << ((c / 3) % 2)) : 64'd0);
         if (c % 3 == 0) q.push_back({2'b01 << ((c / 3) % 2), 1'b0, 16'h0000});
         step();
      end
      req_valid_i = '0;
      drain();
      // backpressure on requester 0 while requester 1 waits
      cam_valid_i = 1'b1;
      cam_val_i = 16'hBEEF;
      req_key_i = 32'h0000_0012;
      req_valid_i = 2'b11;
      resp_ready_i = 2'b10;
      @(negedge clk);
      chk("bp_grant0", 64'(req_ready_o), 64'(2'b01));
      q.push_back({2'b01, 1'b1, 16'hBEEF});
      step();
      req_valid_i = 2'b10;
      @(negedge clk);
      chk("bp_read_strobe", {62'd0, cam_read_o, cam_write_o}, 64'(2'b10));
      step();
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("bp_hold", {resp_valid_o, resp_hit_o, resp_val_o, req_ready_o, cam_read_o, cam_write_o},
             {2'b01, 1'b1, 16'hBEEF, 2'b00, 1'b0, 1'b0});
         step();
      end
      resp_ready_i = 2'b11;
      cam_valid_i = 1'b0;
      @(negedge clk);
      chk("bp_release_ready", 64'(req_ready_o), 64'd0);
      step();
      @(negedge clk);
      chk("bp_grant1", 64'(req_ready_o), 64'(2'b10));
      q.push_back({2'b10, 1'b0, 16'h0000});
      step();
      req_valid_i = '0;
      drain();
      // reset during a read strobe; requester 0's op leaves ptr at 1 unless reset clears it
      cam_valid_i = 1'b1;
      cam_val_i = 16'h1234;
      req_key_i = 32'h0000_0033;
      req_valid_i = 2'b01;
      @(negedge clk);
      chk("rst_issue_grant", 64'(req_ready_o), 64'(2'b01));
      step();
      req_valid_i = '0;
      rst = 1'b1;
      @(negedge clk);
      chk("rst_issue_strobe", {63'd0, cam_read_o}, 64'd1);
      step();
      rst = 1'b0;
      req_valid_i = 2'b11;
      @(negedge clk);
      chk("rst_issue_after", {req_ready_o, resp_valid_o, cam_read_o, cam_write_o},
          {2'b01, 2'b00, 1'b0, 1'b0});
      q.push_back({2'b01, 1'b1, 16'h1234});
      step();
      req_valid_i = '0;
      drain();
      repeat (3) step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/cam_req_arbiter.md
Name: cam_req_arbiter

Overview:
- Shares one CAM instance between NUM_REQ independent requesters.
- Each requester submits read or write operations over a valid/ready request channel and receives results over a valid/ready response channel.
- Selects one request at a time using round-robin arbitration and drives a single-cycle read or write strobe into the CAM.
- Registers the CAM result and returns it to the granted requester. Sits between client logic and the CAM top level.

Parameters:
NUM_REQ, 2, number of requesters; legal range 2..8
KEY_W, 16, CAM key width in bits
VAL_W, 16, CAM value width in bits

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
req_valid_i  in  NUM_REQ  per-requester request valid
req_ready_o  out  NUM_REQ  per-requester request accepted this cycle
req_write_i  in  NUM_REQ  per-requester op: 1 = write, 0 = read
req_key_i  in  NUM_REQ*KEY_W  packed keys; requester r occupies bits [r*KEY_W +: KEY_W]
req_val_i  in  NUM_REQ*VAL_W  packed write values; same packing as keys
resp_valid_o  out  NUM_REQ  per-requester response valid; at most one bit set
resp_ready_i  in  NUM_REQ  per-requester response accepted
resp_hit_o  out  1  read hit flag; always 0 for writes
resp_val_o  out  VAL_W  read data; 0 for writes and read misses
cam_read_o  out  1  read strobe to CAM
cam_write_o  out  1  write strobe to CAM
cam_key_o  out  KEY_W  key to CAM
cam_val_o  out  VAL_W  write value to CAM
cam_valid_i  in  1  CAM hit indication for a read, combinational in the strobe cycle
cam_val_i  in  VAL_W  CAM read data, combinational in the strobe cycle

Behaviour:
- States: IDLE, ISSUE, RESP. Round-robin pointer ptr, width clog2(NUM_REQ).
- Reset:
  - state goes to IDLE and ptr to 0.
  - Latched op, key, value, grant and result registers all go to 0.
  - All outputs read 0 in the cycle after rst is sampled high.
- IDLE:
  - grant = first r with req_valid_i[r] = 1, searching ptr, ptr+1, … wrapping at NUM_REQ-1 to 0.
  - In the same cycle, req_ready_o[grant] = 1 combinationally; all other ready bits are 0.
  - On that edge, latch grant, req_write_i[grant], key and value; set ptr = grant+1 mod NUM_REQ; go to ISSUE.
  - If no request is valid: stay in IDLE, ptr unchanged, all ready bits 0.
- ISSUE, exactly one cycle:
  - cam_key_o and cam_val_o drive the latched key and value.
  - A latched write asserts cam_write_o = 1; a latched read asserts cam_read_o = 1. The two strobes are never high together.
  - On the edge, register the result:
    - Read: resp_hit_o = cam_valid_i; resp_val_o = cam_val_i if cam_valid_i, else 0.
    - Write: resp_hit_o = 0, resp_val_o = 0.
  - Go to RESP.
- RESP:
  - resp_valid_o[grant] = 1 until resp_ready_i[grant] = 1. resp_hit_o and resp_val_o stay stable throughout.
  - On the handshake edge, go to IDLE.
  - resp_ready_i bits of non-granted requesters are ignored.
- Outside ISSUE, cam strobes are 0 and cam_key_o/cam_val_o are 0.
- Outside IDLE, all req_ready_o bits are 0.
- Request fields are sampled only in the ready cycle; changes after acceptance have no effect.
- Latency: request accepted in cycle t → CAM strobe in t+1 → resp_valid_o from t+2. Minimum 3 cycles per operation; no overlap between operations.
- Requests are not queued. A requester may drop req_valid_i before it is granted without error.
- Reset mid-operation:
  - The operation is abandoned and no response is returned.
  - A strobe driven in the cycle rst is sampled has reached the CAM, and its effect is kept.
  - Next cycle: IDLE with ptr = 0.
- Simultaneous rst and a request: reset wins and no grant is issued.

Test Plan:
1. Reset: rst=1 for 2 cycles with req_valid_i=2'b11 → all outputs 0 and no req_ready_o pulse; first grant after release goes to requester 0.
2. Write: requester 0 sends write, key 0x0012, value 0xBEEF, at cycle t → req_ready_o[0]=1 at t; at t+1 cam_write_o=1, cam_key_o=0x0012, cam_val_o=0xBEEF; at t+2 resp_valid_o[0]=1, resp_hit_o=0.
3. Read hit/miss:
   - Requester 1 reads key 0x0012, CAM model returns cam_valid_i=1, cam_val_i=0xBEEF → resp_valid_o[1]=1, resp_hit_o=1, resp_val_o=0xBEEF.
   - Requester 1 reads key 0x0099 with cam_valid_i=0 → resp_hit_o=0, resp_val_o=0.
4. Fairness: both requesters hold req_valid_i=1 and resp_ready_i=1 constantly → grants alternate 0,1,0,1 over 4 operations, each taking 3 cycles.
5. Backpressure: hold resp_ready_i[0]=0 for 5 cycles during RESP while requester 1 is valid → resp outputs stay stable, req_ready_o=0 and cam strobes=0 throughout; requester 1 is granted in the cycle after resp_ready_i[0] rises.
6. Reset in ISSUE: assert rst during a read strobe → no resp_valid_o ever; next cycle IDLE with ptr=0, so requester 0 is granted first.
